cic_readout_sequencer: RTL and testbench

Sequences the CIC3 comb (differentiator) stage and buffers its decimated output for a downstream reader. Holds the differentiators in clear while disabled, and releases them on enable. Discards the first SETTLE_SAMPLES outputs, which are pipeline-fill transients, then pushes every valid output word into a small FWFT FIFO with a ready/valid interface. Sits between the differentiator output register and the readout (SPI/register) logic, all in the divided_clk domain.

---
 rtl/cic_readout_sequencer.sv | 133 +++++++++++++
 tb/tb_cic_readout_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_readout_sequencer.sv
// CIC3 comb-stage sequencer: holds differentiators in clear while disabled, discards
// settling transients, then buffers decimated words in a first-word-fall-through FIFO.
module cic_readout_sequencer #(
  parameter int NUMBITS        = 25,
  parameter int SETTLE_SAMPLES = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 divided_clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUMBITS-1:0]   cic_data,
  output logic                 diff_clear_n,
  output logic [NUMBITS-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 overflow,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [NUMBITS-1:0]   hold_q, hold_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 clear_n_q, clear_n_d;
  logic [NUMBITS-1:0]   mem_q [FIFO_DEPTH];

  logic fifo_valid, fifo_full, pop, push_req, push_ok;

  assign fifo_valid = (wr_ptr_q != rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = fifo_valid && out_ready;
  assign push_req   = (state_q == RUN) && enable;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    hold_d     = hold_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = SETTLE;
          settle_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      RUN: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;

    // Remember the word leaving the head so out_data holds it once empty.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q[AW-1:0]];
    end

    clear_n_d = (state_d != IDLE);
  end

  always_ff @(posedge divided_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      clear_n_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      clear_n_q  <= clear_n_d;
    end
  end

  always_ff @(posedge divided_clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= cic_data;
  end

  assign diff_clear_n = clear_n_q;
  assign out_valid    = fifo_valid;
  assign out_data     = fifo_valid ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;
  assign sample_count = count_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cic_readout_sequencer.sv
// Directed bench for cic_readout_sequencer: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the stimulus script.
module tb_cic_readout_sequencer;

  localparam int NB = 25;
  localparam int S  = 3;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic [NB-1:0] cic_data = '0;

  logic          clr_a, valid_a, ovf_a, busy_a;
  logic [NB-1:0] data_a;
  logic [15:0]   cnt_a;
  logic          clr_b, valid_b, ovf_b, busy_b;
  logic [NB-1:0] data_b;
  logic [3:0]    cnt_b;

  int total = 0;
  int bad   = 0;

  cic_readout_sequencer #(.NUMBITS(NB), .SETTLE_SAMPLES(S), .FIFO_DEPTH(D), .CNT_WIDTH(16)) dut (
    .divided_clk(clk), .reset_n(reset_n), .enable(enable), .cic_data(cic_data),
    .diff_clear_n(clr_a), .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
    .sample_count(cnt_a), .overflow(ovf_a), .busy(busy_a));

  cic_readout_sequencer #(.NUMBITS(NB), .SETTLE_SAMPLES(S), .FIFO_DEPTH(D), .CNT_WIDTH(4)) dut4 (
    .divided_clk(clk), .reset_n(reset_n), .enable(enable), .cic_data(cic_data),
    .diff_clear_n(clr_b), .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
    .sample_count(cnt_b), .overflow(ovf_b), .busy(busy_b));

  always #5 clk = ~clk;

  // Reference model: age = edges since enable was seen (-1 while stopped).
  int            m_age = -1;
  int            m_cnt = 0;
  bit            m_ovf = 1'b0;
  logic [NB-1:0] m_q[$];
  logic [NB-1:0] m_last = '0;
  bit            m_pop, m_push;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_last = '0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_age  = -1;
    end else begin
      m_pop  = (m_q.size() > 0) && out_ready;
      m_push = enable && (m_age >= S);
      if (!enable)        m_age = -1;
      else if (m_age < 0) begin m_age = 0; m_cnt = 0; m_ovf = 1'b0; end
      else                m_age++;
      if (m_push && m_q.size() == D && !m_pop) begin
        m_ovf = 1'b1;
      end else begin
        if (m_pop) m_last = m_q.pop_front();
        if (m_push) begin m_q.push_back(cic_data); m_cnt++; end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [NB-1:0] e_data;
    bit            e_valid;
    #1;
    e_valid = (m_q.size() > 0);
    e_data  = e_valid ? m_q[0] : m_last;
    check("m_clear_n", 64'(clr_a), 64'(m_age >= 0));
    check("m_busy",    64'(busy_a), 64'(m_age >= 0));
    check("m_valid",   64'(valid_a), 64'(e_valid));
    check("m_data",    64'(data_a), 64'(e_data));
    check("m_count",   64'(cnt_a), 64'(m_cnt % 65536));
    check("m_ovf",     64'(ovf_a), 64'(m_ovf));
    check("m4_valid",  64'(valid_b), 64'(e_valid));
    check("m4_data",   64'(data_b), 64'(e_data));
    check("m4_count",  64'(cnt_b), 64'(m_cnt % 16));
    check("m4_ovf",    64'(ovf_b), 64'(m_ovf));
  end

  // Drive inputs for the next rising edge, then return at the following falling edge.
  task automatic step(input logic en, input logic rdy, input int d);
    enable    = en;
    out_ready = rdy;
    cic_data  = NB'(d);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(valid_a), 0);
    check("rst_data",  64'(data_a), 0);
    check("rst_clr",   64'(clr_a), 0);
    check("rst_cnt",   64'(cnt_a), 0);
    reset_n = 1'b1;
    step(0, 0, 0);
    check("idle_valid", 64'(valid_a), 0);
    check("idle_busy",  64'(busy_a), 0);

    // Settle discard: data = edge index, first kept word is 4.
    step(1, 1, 0);
    check("t2_clr_after_e0", 64'(clr_a), 1);
    check("t2_busy", 64'(busy_a), 1);
    for (int k = 1; k <= 3; k++) step(1, 1, k);
    check("t2_no_push_settle", 64'(valid_a), 0);
    step(1, 1, 4);
    check("t2_first_data", 64'(data_a), 4);
    check("t2_first_valid", 64'(valid_a), 1);
    check("t2_count1", 64'(cnt_a), 1);
    step(1, 1, 5);
    check("t2_second_data", 64'(data_a), 5);
    check("t2_count2", 64'(cnt_a), 2);

    // Overflow while stalled, then drain in IDLE.
    step(0, 1, 0);
    step(0, 1, 0);
    check("t3_empty", 64'(valid_a), 0);
    check("t3_hold_data", 64'(data_a), 5);
    check("t3_idle_clr", 64'(clr_a), 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 10 + k);
    check("t3_head10", 64'(data_a), 10);
    check("t3_ovf", 64'(ovf_a), 1);
    check("t3_cnt4", 64'(cnt_a), 4);
    step(0, 1, 0);
    check("t3_drain11", 64'(data_a), 11);
    check("t3_clr_low", 64'(clr_a), 0);
    step(0, 1, 0);
    check("t3_drain12", 64'(data_a), 12);
    step(0, 1, 0);
    check("t3_drain13", 64'(data_a), 13);
    step(0, 1, 0);
    check("t3_drained", 64'(valid_a), 0);
    check("t3_ovf_held", 64'(ovf_a), 1);
    check("t3_cnt_held", 64'(cnt_a), 4);

    // Full FIFO with simultaneous pop and push.
    step(1, 0, 0);
    check("t4_ovf_cleared", 64'(ovf_a), 0);
    check("t4_cnt_cleared", 64'(cnt_a), 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 30 + k);
    check("t4_full_head", 64'(data_a), 30);
    check("t4_cnt4", 64'(cnt_a), 4);
    step(1, 1, 20);
    check("t4_popped", 64'(data_a), 31);
    check("t4_no_ovf", 64'(ovf_a), 0);
    check("t4_cnt5", 64'(cnt_a), 5);

    // Disable with words queued: no push on the stop edge, words still drain.
    step(0, 1, 77);
    check("t5_clr_low", 64'(clr_a), 0);
    check("t5_no_push", 64'(cnt_a), 5);
    check("t5_head32", 64'(data_a), 32);
    step(0, 1, 0);
    check("t5_head33", 64'(data_a), 33);
    step(0, 1, 0);
    check("t5_head20", 64'(data_a), 20);
    step(0, 1, 0);
    check("t5_empty", 64'(valid_a), 0);
    check("t5_hold20", 64'(data_a), 20);

    // Counter wrap on the 4-bit instance.
    for (int k = 0; k < 4; k++) step(1, 1, 0);
    for (int e = 4; e <= 21; e++) begin
      step(1, 1, 100 + e);
      if (e == 18) check("t6_cnt15", 64'(cnt_b), 15);
      if (e == 19) check("t6_cnt0", 64'(cnt_b), 0);
      if (e == 20) begin
        check("t6_cnt1", 64'(cnt_b), 1);
        check("t6_wide_cnt17", 64'(cnt_a), 17);
        check("t6_no_ovf", 64'(ovf_b), 0);
      end
    end

    // Asynchronous reset with three words queued.
    step(1, 0, 200);
    step(1, 0, 201);
    check("t1_queued_head", 64'(data_a), 121);
    #3 reset_n = 1'b0;
    #1;
    check("t1_rst_valid", 64'(valid_a), 0);
    check("t1_rst_data",  64'(data_a), 0);
    check("t1_rst_clr",   64'(clr_a), 0);
    check("t1_rst_busy",  64'(busy_a), 0);
    check("t1_rst_cnt",   64'(cnt_a), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1, 0);
    check("t1_post_valid", 64'(valid_a), 0);
    check("t1_post_clr",   64'(clr_a), 0);
    check("t1_post_busy",  64'(busy_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
